// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One full-adder cell (two
// half-adders plus an OR of their carries) is reused for WIDTH cycles to add
// two WIDTH-bit operands LSB first, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that selects
// A-B (B inverted bit by bit, carry preset to 1).
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;

  // Operand B bit fed to the adder cell; inverted when subtracting.
  logic b_bit;
`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign b_bit = b_q[0] ^ sub_q;
`else
  assign b_bit = b_q[0];
`endif

  logic ha1_s, ha1_c, ha2_c, bit_d, carry_d;

  // Shared full-adder cell: HA1(A0,B0), HA2(s1,carry), carries ORed.
  always_comb begin
    ha1_s   = a_q[0] ^ b_bit;
    ha1_c   = a_q[0] & b_bit;
    bit_d   = ha1_s ^ carry_q;
    ha2_c   = ha1_s & carry_q;
    carry_d = ha1_c | ha2_c;
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            cnt_q  <= '0;
            sum_q  <= '0;   // stale result must not look valid
            cout_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub; // +1 of the two's complement of B
`else
            carry_q <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= {bit_d, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add sequencer. Reuses one full-adder cell, built from two half-adder stages plus an OR on the two carries, over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- Owns operand/result shift registers, the carry flip-flop, a bit counter and a start/busy/done handshake.
- Sits between a requesting controller and the shared 1-bit add datapath; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; not overridden by users.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
- sum  output  WIDTH  registered result; held until the next accepted start.
- cout  output  1  registered carry out of the MSB; held like sum.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Counter, carry FF and shift registers cleared.
  - rst overrides every other input at that edge.
- States: IDLE, RUN, DONE. Encoding is free; it is not visible at the ports.
- IDLE, start=1 at edge T0:
  - Load shift regs A←a, B←b; clear carry FF; counter=0.
  - Clear sum and cout to 0; go to RUN.
- IDLE, start=0: hold; sum and cout keep their last values.
- RUN, each edge:
  - bit = A[0]^B[0]^carry.
  - carry ← (A[0]&B[0]) | ((A[0]^B[0])&carry), i.e. HA1(A0,B0) then HA2(s1,carry), carries ORed.
  - Result reg shifts right with bit entering at the MSB; A and B shift right.
  - counter increments.
- Exit from RUN: on the edge where counter==WIDTH-1 (edge T_WIDTH):
  - Final bit shifts in; cout ← new carry; go to DONE.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE with done=0.
- Latency:
  - Start sampled at T0; done is high during the cycle after T_WIDTH.
  - Earliest next start is accepted at edge T_WIDTH+2. Throughput is one add per WIDTH+2 cycles.
- busy: high from after T0 until the DONE→IDLE edge.
- start while busy (RUN or DONE): ignored. No queuing, no effect on the operation in flight.
- Operand changes after T0: no effect; operands are captured at T0.
- sum visibility:
  - sum shows the shifting partial result during RUN; only valid when done=1 and afterwards.
  - Cleared at the accepted start so stale results are not mistaken for valid ones.
- Wrap-around: modulo-2^WIDTH; overflow is reported only through cout.
- Reset mid-operation (RUN or DONE): abort immediately to the reset values; no done pulse.
- start and rst both high at one edge: reset wins and no operation starts.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with start at T0 and stored.
  - If sub=1: the B stream is inverted bit by bit and the carry FF is preset to 1 at T0, computing A-B modulo 2^WIDTH.
  - cout=1 means no borrow (A>=B unsigned).
  - Timing and handshake unchanged.
- Not defined: no sub port; add only; carry FF cleared at T0.

Test Plan (WIDTH=8):
1. rst=1 for 2 cycles, then start=1 with a=0x5A, b=0x33 → busy=1 for 9 cycles; done pulses once, 9 cycles after T0; sum=0x8D, cout=0.
2. a=0xFF, b=0x01 → sum=0x00, cout=1. a=0xFF, b=0xFF → sum=0xFE, cout=1.
3. start a=0x10, b=0x20; hold start=1 with a=0xAA, b=0x55 for the whole operation → one done only, sum=0x30; second request accepted only once back in IDLE.
4. start a=0x7F, b=0x7F; assert rst at the 4th RUN edge → next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
5. Back-to-back: start re-asserted in the first IDLE cycle after done with a=0x01, b=0x02 → accepted; sum=0x03 valid at its own done; prior sum held until the accepted start.
6. With SERIAL_ADD_SUB_EN: sub=1, a=0x05, b=0x03 → sum=0x02, cout=1. sub=1, a=0x03, b=0x05 → sum=0xFE, cout=0.
